// File: rtl/pcpi_issuer.sv
// rtl/pcpi_issuer.sv - PCPI initiator: issues offloaded instructions and returns results or an illegal-instruction trap
//
// Optional build macro: PCPI_WATCHDOG_EN (adds a WATCHDOG_CYCLES bound on the WAIT state)
//
// Ports:
//   clk, reset                      clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready             core -> issuer instruction handshake (req_ready = state is IDLE)
//   req_insn/req_rs1/req_rs2        instruction word and operands from the core
//   pcpi_valid/insn/rs1/rs2         registered request towards the PCPI responders
//   pcpi_wr/rd/busy/ready           responder claim, completion and result
//   rsp_valid/rsp_ready             issuer -> core response handshake
//   rsp_wr/rsp_rd/rsp_trap          write-back enable, result (0 unless rsp_wr), illegal-instruction trap
module pcpi_issuer #(
    parameter int TIMEOUT_CYCLES  = 16,
    parameter int WATCHDOG_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_insn,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    output logic        pcpi_valid,
    output logic [31:0] pcpi_insn,
    output logic [31:0] pcpi_rs1,
    output logic [31:0] pcpi_rs2,
    input  logic        pcpi_wr,
    input  logic [31:0] pcpi_rd,
    input  logic        pcpi_busy,
    input  logic        pcpi_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_wr,
    output logic [31:0] rsp_rd,
    output logic        rsp_trap
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    // Counter value on the last allowed unclaimed cycle; reaching it with no claim traps.
    localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    generate
        if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255 ||
            WATCHDOG_CYCLES < 2 || WATCHDOG_CYCLES > 65535) begin : g_bad_param
            $error("pcpi_issuer: parameter out of range");
        end
    endgenerate

    state_t      state_q, state_d;
    logic        pcpi_valid_q, pcpi_valid_d;
    logic [31:0] insn_q, insn_d;
    logic [31:0] rs1_q, rs1_d;
    logic [31:0] rs2_q, rs2_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_wr_q, rsp_wr_d;
    logic [31:0] rsp_rd_q, rsp_rd_d;
    logic        rsp_trap_q, rsp_trap_d;
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;
`ifdef PCPI_WATCHDOG_EN
    localparam logic [15:0] WD_LAST = 16'(WATCHDOG_CYCLES - 1);
    logic [15:0] wd_cnt_q, wd_cnt_d;
`endif

    logic finish;   // responder completed this cycle
    logic trap;     // give up on the instruction this cycle

    always_comb begin
        state_d      = state_q;
        pcpi_valid_d = pcpi_valid_q;
        insn_d       = insn_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_wr_d     = rsp_wr_q;
        rsp_rd_d     = rsp_rd_q;
        rsp_trap_d   = rsp_trap_q;
        tmo_cnt_d    = tmo_cnt_q;
`ifdef PCPI_WATCHDOG_EN
        wd_cnt_d     = wd_cnt_q;
`endif
        finish       = 1'b0;
        trap         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    insn_d       = req_insn;
                    rs1_d        = req_rs1;
                    rs2_d        = req_rs2;
                    pcpi_valid_d = 1'b1;
                    tmo_cnt_d    = 8'd0;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // ready has priority over both the claim and the timeout
                if (pcpi_ready) begin
                    finish = 1'b1;
                end else if (pcpi_busy) begin
                    state_d = S_WAIT;
`ifdef PCPI_WATCHDOG_EN
                    wd_cnt_d = 16'd0;
`endif
                end else if (tmo_cnt_q == TMO_LAST) begin
                    trap = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            S_WAIT: begin
                // a claimed instruction never returns to ISSUE, even if busy drops
                if (pcpi_ready) begin
                    finish = 1'b1;
`ifdef PCPI_WATCHDOG_EN
                end else if (wd_cnt_q == WD_LAST) begin
                    trap = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + 16'd1;
`endif
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (finish) begin
            pcpi_valid_d = 1'b0;
            rsp_valid_d  = 1'b1;
            rsp_wr_d     = pcpi_wr;
            rsp_rd_d     = pcpi_wr ? pcpi_rd : 32'd0;
            rsp_trap_d   = 1'b0;
            state_d      = S_RESP;
        end else if (trap) begin
            pcpi_valid_d = 1'b0;
            rsp_valid_d  = 1'b1;
            rsp_wr_d     = 1'b0;
            rsp_rd_d     = 32'd0;
            rsp_trap_d   = 1'b1;
            state_d      = S_RESP;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pcpi_valid_q <= 1'b0;
            insn_q       <= 32'd0;
            rs1_q        <= 32'd0;
            rs2_q        <= 32'd0;
            rsp_valid_q  <= 1'b0;
            rsp_wr_q     <= 1'b0;
            rsp_rd_q     <= 32'd0;
            rsp_trap_q   <= 1'b0;
            tmo_cnt_q    <= 8'd0;
`ifdef PCPI_WATCHDOG_EN
            wd_cnt_q     <= 16'd0;
`endif
        end else begin
            state_q      <= state_d;
            pcpi_valid_q <= pcpi_valid_d;
            insn_q       <= insn_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_wr_q     <= rsp_wr_d;
            rsp_rd_q     <= rsp_rd_d;
            rsp_trap_q   <= rsp_trap_d;
            tmo_cnt_q    <= tmo_cnt_d;
`ifdef PCPI_WATCHDOG_EN
            wd_cnt_q     <= wd_cnt_d;
`endif
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign pcpi_valid = pcpi_valid_q;
    assign pcpi_insn  = insn_q;
    assign pcpi_rs1   = rs1_q;
    assign pcpi_rs2   = rs2_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_wr     = rsp_wr_q;
    assign rsp_rd     = rsp_rd_q;
    assign rsp_trap   = rsp_trap_q;

endmodule

// File: tb/tb_pcpi_issuer.sv
// tb/tb_pcpi_issuer.sv - scoreboard testbench for pcpi_issuer
module tb_pcpi_issuer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_insn = '0, req_rs1 = '0, req_rs2 = '0;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
    logic        pcpi_wr = 1'b0;
    logic [31:0] pcpi_rd = '0;
    logic        pcpi_busy = 1'b0;
    logic        pcpi_ready = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_wr;
    logic [31:0] rsp_rd;
    logic        rsp_trap;

    int n_cmp = 0;
    int n_bad = 0;

    // expected response: {wr, trap, rd}
    logic [33:0] sb[$];

    pcpi_issuer #(.TIMEOUT_CYCLES(16), .WATCHDOG_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_insn(req_insn), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
        .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
        .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
        .pcpi_busy(pcpi_busy), .pcpi_ready(pcpi_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_wr(rsp_wr), .rsp_rd(rsp_rd), .rsp_trap(rsp_trap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every consumed response must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rsp: wr=%0b trap=%0b rd=0x%08h with empty scoreboard",
                         rsp_wr, rsp_trap, rsp_rd);
            end else begin
                logic [33:0] e;
                e = sb.pop_front();
                check("rsp_wr",   {31'd0, rsp_wr},   {31'd0, e[33]});
                check("rsp_trap", {31'd0, rsp_trap}, {31'd0, e[32]});
                check("rsp_rd",   rsp_rd,            e[31:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a request; returns #1 into the first cycle after the accepting edge.
    task automatic issue(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2);
        int n;
        req_valid = 1'b1;
        req_insn  = insn;
        req_rs1   = rs1;
        req_rs2   = rs2;
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            if (req_ready) break;
            n++;
        end
        if (n == 50) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_timeout: req_ready low for 50 cycles, expected 1");
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_scoreboard_empty", sb.size(), 0);
        tick();
    endtask

    task automatic respond_now(input logic wr, input logic [31:0] rd);
        pcpi_ready = 1'b1;
        pcpi_wr    = wr;
        pcpi_rd    = rd;
        @(negedge clk);
        check("pcpi_valid_while_ready", {31'd0, pcpi_valid}, 32'd1);
        tick();
        pcpi_ready = 1'b0;
        pcpi_wr    = 1'b0;
        pcpi_rd    = 32'd0;
    endtask

    initial begin
        int vcnt;
        logic [31:0] hold_rd;

        repeat (2) tick();
        reset = 1'b0;
        @(negedge clk);
        check("reset_req_ready",  {31'd0, req_ready},  32'd1);
        check("reset_pcpi_valid", {31'd0, pcpi_valid}, 32'd0);
        check("reset_rsp_valid",  {31'd0, rsp_valid},  32'd0);
        check("reset_pcpi_insn",  pcpi_insn,           32'd0);
        check("reset_rsp_rd",     rsp_rd,              32'd0);
        tick();

        // single-cycle responder
        issue(32'h02B50533, 32'd6, 32'd7);
        sb.push_back({1'b1, 1'b0, 32'd42});
        pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'd42;
        @(negedge clk);
        check("t1_pcpi_valid_c1", {31'd0, pcpi_valid}, 32'd1);
        check("t1_pcpi_insn",     pcpi_insn,           32'h02B50533);
        check("t1_pcpi_rs1",      pcpi_rs1,            32'd6);
        check("t1_pcpi_rs2",      pcpi_rs2,            32'd7);
        check("t1_req_ready_c1",  {31'd0, req_ready},  32'd0);
        tick();
        pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_rd = 32'd0;
        @(negedge clk);
        check("t1_rsp_valid_c2",  {31'd0, rsp_valid},  32'd1);
        check("t1_pcpi_valid_c2", {31'd0, pcpi_valid}, 32'd0);
        tick();
        @(negedge clk);
        check("t1_rsp_valid_after", {31'd0, rsp_valid}, 32'd0);
        check("t1_req_ready_after", {31'd0, req_ready}, 32'd1);
        drain();

        // multi-cycle responder; busy drops at cycle 11 but ready comes only at 34
        issue(32'h02C5C5B3, 32'd100, 32'd3);
        sb.push_back({1'b1, 1'b0, 32'hFFFFFFFF});
        vcnt = 0;
        for (int i = 1; i <= 34; i++) begin
            pcpi_busy  = (i <= 10);
            pcpi_ready = (i == 34);
            pcpi_wr    = (i == 34);
            pcpi_rd    = (i == 34) ? 32'hFFFFFFFF : 32'd0;
            @(negedge clk);
            if (pcpi_valid) vcnt++;
            tick();
        end
        pcpi_busy = 1'b0; pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_rd = 32'd0;
        @(negedge clk);
        check("t2_pcpi_valid_cycles", vcnt,                34);
        check("t2_pcpi_valid_c35",    {31'd0, pcpi_valid}, 32'd0);
        drain();

        // no claim: trap after 16 unclaimed cycles
        issue(32'h0000000B, 32'd1, 32'd2);
        sb.push_back({1'b0, 1'b1, 32'd0});
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 16) begin
                check("t3_pcpi_valid_c16", {31'd0, pcpi_valid}, 32'd1);
                check("t3_rsp_valid_c16",  {31'd0, rsp_valid},  32'd0);
            end
            tick();
        end
        @(negedge clk);
        check("t3_rsp_valid_c17",  {31'd0, rsp_valid},  32'd1);
        check("t3_pcpi_valid_c17", {31'd0, pcpi_valid}, 32'd0);
        drain();

        // ready on the 16th unclaimed cycle beats the trap
        issue(32'h0000000B, 32'd1, 32'd2);
        sb.push_back({1'b1, 1'b0, 32'h00000055});
        repeat (15) tick();
        respond_now(1'b1, 32'h00000055);
        drain();

        // backpressure
        rsp_ready = 1'b0;
        issue(32'h02B50533, 32'd9, 32'd9);
        sb.push_back({1'b1, 1'b0, 32'h0000A5A5});
        respond_now(1'b1, 32'h0000A5A5);
        hold_rd = rsp_rd;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0 || i == 9) begin
                check("t4_rsp_valid_held", {31'd0, rsp_valid}, 32'd1);
                check("t4_rsp_rd_stable",  rsp_rd,             32'h0000A5A5);
                check("t4_req_ready_low",  {31'd0, req_ready}, 32'd0);
            end
            tick();
        end
        check("t4_rsp_rd_unchanged", rsp_rd, hold_rd);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("t4_req_ready_at_consume", {31'd0, req_ready}, 32'd0);
        tick();
        @(negedge clk);
        check("t4_req_ready_next", {31'd0, req_ready}, 32'd1);
        drain();

        // ready with wr=0 zeroes the result
        issue(32'h02B50533, 32'd1, 32'd1);
        sb.push_back({1'b0, 1'b0, 32'd0});
        respond_now(1'b0, 32'h00001234);
        drain();

        // reset while in WAIT
        issue(32'hDEADBEEF, 32'h11111111, 32'h22222222);
        pcpi_busy = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("t6_pcpi_valid_rst", {31'd0, pcpi_valid}, 32'd0);
        check("t6_pcpi_insn_rst",  pcpi_insn,           32'd0);
        check("t6_pcpi_rs1_rst",   pcpi_rs1,            32'd0);
        check("t6_rsp_valid_rst",  {31'd0, rsp_valid},  32'd0);
        tick();
        reset = 1'b0;
        pcpi_busy = 1'b0; pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'd99;
        repeat (3) begin
            @(negedge clk);
            check("t6_stale_ready_ignored", {31'd0, rsp_valid}, 32'd0);
            tick();
        end
        pcpi_ready = 1'b0; pcpi_wr = 1'b0; pcpi_rd = 32'd0;
        issue(32'h02B50533, 32'd2, 32'd3);
        sb.push_back({1'b1, 1'b0, 32'd6});
        respond_now(1'b1, 32'd6);
        drain();

        // WAIT bound
        issue(32'h0200000B, 32'd5, 32'd5);
        pcpi_busy = 1'b1;
`ifdef PCPI_WATCHDOG_EN
        sb.push_back({1'b0, 1'b1, 32'd0});
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 9)  check("t7_wd_rsp_valid_c9",  {31'd0, rsp_valid}, 32'd0);
            if (i == 10) check("t7_wd_rsp_valid_c10", {31'd0, rsp_valid}, 32'd1);
            tick();
        end
        pcpi_busy = 1'b0;
`else
        repeat (40) tick();
        @(negedge clk);
        check("t7_wait_pcpi_valid", {31'd0, pcpi_valid}, 32'd1);
        check("t7_wait_rsp_valid",  {31'd0, rsp_valid},  32'd0);
        tick();
        pcpi_busy = 1'b0;
        sb.push_back({1'b1, 1'b0, 32'd7});
        respond_now(1'b1, 32'd7);
`endif
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/pcpi_issuer.md
Name: pcpi_issuer

Overview:
- Initiator end of the PCPI coprocessor interface, sitting between the core's execute stage and the PCPI responders (M unit and custom-instruction units).
- Accepts one offloaded instruction with its operands from the core and drives pcpi_valid/insn/rs1/rs2.
- Waits for a responder to claim and finish the instruction, then returns the result to the core with backpressure.
- Raises an illegal-instruction trap when no responder claims the instruction within a bounded number of cycles.

Parameters:
- TIMEOUT_CYCLES, 16: consecutive unclaimed ISSUE cycles before a trap; legal range 2..255.
- WATCHDOG_CYCLES, 1024: maximum cycles in WAIT; used only with PCPI_WATCHDOG_EN; legal range 2..65535.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  core offers an instruction
- req_ready  out  1  issuer can accept; high only in IDLE
- req_insn  in  32  instruction word
- req_rs1  in  32  operand 1
- req_rs2  in  32  operand 2
- pcpi_valid  out  1  request to responders
- pcpi_insn  out  32  registered copy of req_insn
- pcpi_rs1  out  32  registered copy of req_rs1
- pcpi_rs2  out  32  registered copy of req_rs2
- pcpi_wr  in  1  responder writes rd
- pcpi_rd  in  32  responder result
- pcpi_busy  in  1  responder has claimed the instruction
- pcpi_ready  in  1  responder result valid this cycle
- rsp_valid  out  1  response available to core
- rsp_ready  in  1  core consumes response
- rsp_wr  out  1  core must write rsp_rd to rd
- rsp_rd  out  32  result; 0 when rsp_wr=0
- rsp_trap  out  1  illegal instruction; no responder claimed it

Behaviour:
- Reset (asynchronous, any state): state=IDLE; counters=0; pcpi_valid, rsp_valid, rsp_wr, rsp_trap = 0; pcpi_insn, pcpi_rs1, pcpi_rs2, rsp_rd = 0. An in-flight request is dropped and no response is produced.
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered except req_ready, which is (state==IDLE).
- IDLE:
  - req_valid&&req_ready at edge N: capture insn/rs1/rs2; pcpi_valid=1 from cycle N+1; go to ISSUE; timeout counter cleared.
- ISSUE (pcpi_valid=1):
  - pcpi_ready sampled high: latch rsp_wr=pcpi_wr and rsp_rd = pcpi_wr ? pcpi_rd : 0; rsp_trap=0; pcpi_valid=0 and rsp_valid=1 next cycle; go to RESP. This applies even if pcpi_ready arrives in the first ISSUE cycle.
  - Else if pcpi_busy high: go to WAIT; pcpi_valid stays 1.
  - Else: increment counter. When TIMEOUT_CYCLES consecutive cycles have been sampled with busy=0 and ready=0, go to RESP next cycle with rsp_trap=1, rsp_wr=0, rsp_rd=0; pcpi_valid drops.
  - pcpi_ready on the final timeout cycle wins over the trap.
- WAIT (pcpi_valid=1):
  - Stay until pcpi_ready is high, then act as ISSUE's ready branch.
  - Busy deasserting without ready does not return to ISSUE; keep waiting.
  - No timeout in this state unless PCPI_WATCHDOG_EN is defined.
- RESP:
  - rsp_valid and rsp_* are held stable until rsp_ready is sampled high.
  - On that edge: rsp_valid=0 and go to IDLE. req_ready rises the following cycle; the earliest next issue is one cycle after the response is consumed.
  - pcpi_* inputs are ignored in RESP and IDLE.
- pcpi_insn/rs1/rs2 are stable from capture until the next accepted request.
- Minimum latency: req accept at N, responder ready at N+1, rsp_valid at N+2.

Optional Feature:
- Macro: PCPI_WATCHDOG_EN.
- Defined: a 16-bit WAIT counter increments each WAIT cycle without pcpi_ready. On reaching WATCHDOG_CYCLES, the block drops pcpi_valid and enters RESP with rsp_trap=1, rsp_wr=0, rsp_rd=0. pcpi_ready on the expiry cycle wins.
- Undefined: no WAIT counter; WAIT can last indefinitely.

Test Plan:
- Single-cycle responder: issue insn=0x02B50533, rs1=6, rs2=7; responder asserts ready+wr with rd=42 in the first ISSUE cycle -> rsp_valid two cycles after accept, rsp_wr=1, rsp_rd=42, rsp_trap=0, pcpi_valid high exactly one cycle.
- Multi-cycle responder: busy asserted in cycle 1, ready+wr with rd=0xFFFFFFFF at cycle 34 -> pcpi_valid high cycles 1-34, rsp_rd=0xFFFFFFFF, no trap.
- No claim: idle responders, TIMEOUT_CYCLES=16 -> rsp_trap=1, rsp_wr=0, rsp_rd=0, rsp_valid asserted the cycle after the 16th unclaimed cycle. Ready on the 16th cycle instead -> normal response, no trap.
- Backpressure: rsp_ready held low 10 cycles after rsp_valid -> rsp_* stable; req_ready=0 throughout; req_ready=1 one cycle after rsp_ready is sampled.
- Ready with wr=0 and rd=0x1234 -> rsp_wr=0, rsp_rd=0.
- Reset pulse while in WAIT -> all outputs 0 immediately; later pcpi_ready is ignored; the next request proceeds normally. With PCPI_WATCHDOG_EN and WATCHDOG_CYCLES=8, busy held with no ready -> trap after 8 WAIT cycles.
